// File: rtl/cpu_instruction_dumper.sv
// cpu_instruction_dumper: streams iRAM words 0..NUM_WORDS-1 out over a UART byte interface,
// framed by a 3-byte START_FLAG header and a 3-byte END_FLAG trailer, each word LSB-first.
// Latency: 3 + 5*NUM_WORDS + 3 (+1 checksum) + 2 cycles per dump when tx_ready is held high.
// Backpressure: tx_byte holds steady while tx_valid && !tx_ready; a byte moves on tx_valid && tx_ready.
// Optional feature macro DUMP_CHECKSUM_EN: appends an 8-bit XOR of all image bytes after the trailer.
module cpu_instruction_dumper #(
    parameter int          NUM_WORDS  = 256,
    parameter logic [23:0] START_FLAG = 24'hFF0000,
    parameter logic [23:0] END_FLAG   = 24'hFFF000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HALT_flag,
    input  logic        dump_req,
    input  logic        tx_ready,
    input  logic [23:0] iRAM_data_out,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    output logic        iRAM_read_enable,
    output logic [7:0]  extern_iRAM_addr,
    output logic        cpu_paused,
    output logic        dump_busy
);

    // Index of the final word; the address never needs to wrap, so 8 bits covers 1..256 words.
    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RD,
        S_WT,
        S_SEND,
        S_TRL,
        S_DONE
`ifdef DUMP_CHECKSUM_EN
        ,
        S_CSUM
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_byte_idx;
    logic [7:0]  r_wcnt;
    logic [7:0]  r_addr;
    logic [23:0] r_word;
    logic        r_paused;
    logic        r_armed;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_tx_valid;
    logic        w_rd_en;
    logic        w_accept;
    logic        w_xfer;
    logic        w_last_byte;
    logic        w_last_word;
    logic [23:0] w_word;
    logic [7:0]  w_tx_byte;

    assign w_last_byte = (r_byte_idx == 2'd2);
    assign w_last_word = (r_wcnt == LAST_IDX);
    assign w_xfer      = w_tx_valid & tx_ready;

    // State register; reset aborts any dump in flight without finishing the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state strobes; a new dump needs HALT, a request and a prior low request level.
    always_comb begin
        w_next     = r_state;
        w_tx_valid = 1'b0;
        w_rd_en    = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dump_req && HALT_flag && r_armed) begin
                    w_accept = 1'b1;
                    w_next   = S_HDR;
                end
            end
            S_HDR: begin
                w_tx_valid = 1'b1;
                if (tx_ready && w_last_byte) begin
                    w_next = S_RD;
                end
            end
            S_RD: begin
                w_rd_en = 1'b1;
                w_next  = S_WT;
            end
            S_WT: begin
                w_next = S_SEND;
            end
            S_SEND: begin
                w_tx_valid = 1'b1;
                if (tx_ready && w_last_byte) begin
                    w_next = w_last_word ? S_TRL : S_RD;
                end
            end
            S_TRL: begin
                w_tx_valid = 1'b1;
                if (tx_ready && w_last_byte) begin
`ifdef DUMP_CHECKSUM_EN
                    w_next = S_CSUM;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                w_tx_valid = 1'b1;
                if (tx_ready) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Select the word being framed and the byte within it; zero whenever nothing is offered.
    always_comb begin
        w_word    = 24'h000000;
        w_tx_byte = 8'h00;
        case (r_state)
            S_HDR:   w_word = START_FLAG;
            S_SEND:  w_word = r_word;
            S_TRL:   w_word = END_FLAG;
            default: w_word = 24'h000000;
        endcase
        case (r_byte_idx)
            2'd0:    w_tx_byte = w_word[7:0];
            2'd1:    w_tx_byte = w_word[15:8];
            default: w_tx_byte = w_word[23:16];
        endcase
`ifdef DUMP_CHECKSUM_EN
        if (r_state == S_CSUM) begin
            w_tx_byte = r_csum;
        end
`endif
    end

    // Datapath: byte index, word counter/address, captured read data, pause and re-arm tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx <= 2'd0;
            r_wcnt     <= 8'd0;
            r_addr     <= 8'd0;
            r_word     <= 24'h000000;
            r_paused   <= 1'b0;
            r_armed    <= 1'b1;
        end else begin
            // A request held high across a dump must drop before it can start another.
            if (!dump_req) begin
                r_armed <= 1'b1;
            end
            if (w_accept) begin
                r_armed    <= 1'b0;
                r_paused   <= 1'b1;
                r_addr     <= 8'd0;
                r_wcnt     <= 8'd0;
                r_byte_idx <= 2'd0;
            end
            // Only the 3-byte framed states walk the byte index; it wraps 2 -> 0.
            if (w_xfer && (r_state == S_HDR || r_state == S_SEND || r_state == S_TRL)) begin
                r_byte_idx <= w_last_byte ? 2'd0 : r_byte_idx + 2'd1;
            end
            if (r_state == S_WT) begin
                r_word <= iRAM_data_out;
            end
            // Step to the next word after its last byte; the final address is left in place.
            if (w_xfer && r_state == S_SEND && w_last_byte && !w_last_word) begin
                r_addr <= r_addr + 8'd1;
                r_wcnt <= r_wcnt + 8'd1;
            end
            if (r_state == S_DONE) begin
                r_paused <= 1'b0;
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Running XOR over image bytes only; cleared as the header begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum <= 8'h00;
        end else if (w_accept) begin
            r_csum <= 8'h00;
        end else if (w_xfer && r_state == S_SEND) begin
            r_csum <= r_csum ^ w_tx_byte;
        end
    end
`endif

    assign tx_valid         = w_tx_valid;
    assign tx_byte          = w_tx_byte;
    assign iRAM_read_enable = w_rd_en;
    assign extern_iRAM_addr = r_addr;
    assign cpu_paused       = r_paused;
    assign dump_busy        = (r_state != S_IDLE);

endmodule
